adr_div_pipe: RTL and testbench
===============================

Name: adr_div_pipe

Overview:
- Pipelined address splitter: divides a flat memory address by a runtime-selectable divisor.
- Returns quotient (bank/row index) and remainder (in-bank offset), one restoring-division step per stage.
- Generalises the fixed divide-by-12 bank mapper: parametrised widths, runtime divisor, valid/ready flow control with backpressure, overflow and divide-by-zero flags.
- Sits between the address generator and the SMA data-memory bank decoder.

Parameters:
ADR_W, 9, input address width
QUO_W, 6, quotient width; also pipeline depth (stages)
DIV_W, 4, divisor and remainder width
DEF_DIV, 12, divisor used when div_sel=0

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  block accepts request this cycle
in_adr  in  ADR_W  dividend address
div_sel  in  1  0: use DEF_DIV; 1: use in_div
in_div  in  DIV_W  runtime divisor
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_quo  out  QUO_W  quotient
out_rem  out  DIV_W  remainder
out_ovf  out  1  quotient did not fit QUO_W bits
out_dz  out  1  divisor was zero

Behaviour:
- Clock/reset: single clock clk. rst_n is asynchronous, active-low.
- Reset values: all stage valid bits 0, out_valid=0, out_quo=0, out_rem=0, out_ovf=0, out_dz=0. in_ready=1 after reset.
- Global advance: adv = !out_valid || out_ready.
  - in_ready = adv.
  - When adv=1, every stage shifts forward one slot, bubbles included; when adv=0, all stages hold.
- Accept: in_valid && in_ready on a rising edge captures in_adr and the effective divisor (DEF_DIV or in_div). The divisor travels with the data; changing in_div later does not affect in-flight items.
- Stage k (k = QUO_W-1 down to 0):
  - If partial >= (div << k), then quotient bit k = 1 and partial -= div << k; else bit k = 0.
  - Compare and subtract in width W = max(ADR_W, DIV_W+QUO_W), zero-extended; no truncation of div << k.
- Latency: out_valid rises QUO_W cycles after the accepting edge when out_ready is held high. Throughput is 1 result/cycle.
- Ordering: results leave strictly in acceptance order. No item is dropped or duplicated under any out_ready pattern.
- Normal case: out_quo = floor(adr/div), out_rem = adr mod div < div.
- Overflow: detected at acceptance as div != 0 && adr >= (div << QUO_W). Flag carried down the pipe. Result: out_ovf=1, out_quo = all ones, out_rem = 0.
- Divide-by-zero: effective div = 0 gives out_dz=1, out_ovf=0, out_quo = all ones, out_rem = 0. Takes the same latency and slot as a normal item.
- Result hold: out_* remain stable while out_valid && !out_ready.
- Simultaneous events: output consumption and new input acceptance in the same cycle are both allowed (adv=1).
- Reset mid-operation: all in-flight items are discarded, out_valid drops immediately (asynchronous), and no result from before reset ever appears afterwards.
- Restriction: DEF_DIV must fit DIV_W bits and be nonzero; elaboration fails otherwise.

Test Plan:
1. Defaults, div_sel=0, out_ready=1:
   - in_adr = 0, 300, 311, 511 on back-to-back cycles → quo/rem = 0/0, 25/0, 25/11, 42/7.
   - First out_valid exactly 6 cycles after the first accept; results on consecutive cycles.
2. Runtime divisor: div_sel=1, in_div=5, adr=319 → quo=63, rem=4, ovf=0. Same divisor, adr=320 → ovf=1, quo=63, rem=0.
3. Divisor change in flight:
   - Accept adr=100 with in_div=7, then set in_div=3 next cycle and accept adr=100.
   - → first result 14/2, second 33/1.
4. Divide-by-zero: div_sel=1, in_div=0, adr=50 → dz=1, quo=63, rem=0. Neighbouring valid items are unaffected.
5. Backpressure:
   - Stream 10 addresses (adr = 12*i+i, i = 0..9, div=12), with out_ready low for 3 cycles mid-stream.
   - → in_ready low exactly while out_valid && !out_ready; outputs held stable; all 10 results correct and in order (quo=i, rem=i for i ≤ 9).
6. Reset mid-stream: assert rst_n=0 with 4 items in flight → out_valid=0 at once. After release, first new item adr=24 gives quo=2, rem=0 with no stale result emitted.

Source files
------------

// File: rtl/adr_div_pipe.sv
// ----------------------------------------------------------------------------
// adr_div_pipe
//
// Pipelined address splitter. Divides a flat memory address by either a fixed
// default divisor or a runtime divisor and returns the quotient (bank/row
// index) and remainder (in-bank offset). One restoring-division step is done
// per pipeline stage, most significant quotient bit first. Sits between the
// address generator and the data-memory bank decoder.
//
// Pipeline layout (QUO_W + 1 register ranks):
//   rank 0        : raw capture of the accepted address, effective divisor and
//                   the overflow / divide-by-zero flags.
//   rank j (1..)  : quotient bits QUO_W-1 .. QUO_W-j resolved.
//   output rank   : last step (bit 0) plus flag-driven result forcing.
//   So out_valid rises QUO_W clock edges after the accepting edge.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. ready must not depend on valid of the same interface. The whole pipe
// advances as one unit: adv = !out_valid || out_ready. in_ready equals adv,
// and every rank (bubbles included) shifts forward when adv is high and holds
// otherwise, so out_* stay stable while out_valid && !out_ready.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset, flushes every in-flight item
//   in_valid   request valid
//   in_ready   block accepts a request this cycle
//   in_adr     dividend address            [ADR_W]
//   div_sel    0: use DEF_DIV, 1: use in_div
//   in_div     runtime divisor             [DIV_W]
//   out_valid  result valid
//   out_ready  consumer accepts result
//   out_quo    quotient                    [QUO_W]
//   out_rem    remainder                   [DIV_W]
//   out_ovf    quotient did not fit QUO_W bits (quo forced all ones, rem 0)
//   out_dz     divisor was zero            (quo forced all ones, rem 0)
// ----------------------------------------------------------------------------
module adr_div_pipe #(
  parameter int ADR_W   = 9,
  parameter int QUO_W   = 6,
  parameter int DIV_W   = 4,
  parameter int DEF_DIV = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ADR_W-1:0] in_adr,
  input  logic             div_sel,
  input  logic [DIV_W-1:0] in_div,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [QUO_W-1:0] out_quo,
  output logic [DIV_W-1:0] out_rem,
  output logic             out_ovf,
  output logic             out_dz
);

  // Datapath width: wide enough for the address and for div << (QUO_W-1)
  // and div << QUO_W, so no shifted divisor is ever truncated.
  localparam int W    = (ADR_W > DIV_W + QUO_W) ? ADR_W : DIV_W + QUO_W;
  localparam int LAST = QUO_W - 1;

  localparam logic [DIV_W-1:0] DEF_DIV_V = DIV_W'(DEF_DIV);

  // The default divisor must be nonzero and representable in DIV_W bits.
  generate
    if (DEF_DIV < 1 || DEF_DIV > ((1 << DIV_W) - 1)) begin : g_bad_def_div
      $error("adr_div_pipe: DEF_DIV must be nonzero and fit in DIV_W bits");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Flow control
  // --------------------------------------------------------------------------
  logic adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // --------------------------------------------------------------------------
  // Acceptance-side decode
  // --------------------------------------------------------------------------
  logic [DIV_W-1:0] eff_div;
  logic [W-1:0]     adr_ext;
  logic [W-1:0]     ovf_lim;
  logic             in_ovf;
  logic             in_dz;

  assign eff_div = div_sel ? in_div : DEF_DIV_V;
  assign adr_ext = W'(in_adr);
  assign ovf_lim = W'(eff_div) << QUO_W;
  assign in_dz   = (eff_div == '0);
  // A quotient needs more than QUO_W bits exactly when adr >= div * 2^QUO_W.
  assign in_ovf  = !in_dz && (adr_ext >= ovf_lim);

  // --------------------------------------------------------------------------
  // Pipeline ranks
  // --------------------------------------------------------------------------
  logic             v_q    [QUO_W];
  logic [W-1:0]     part_q [QUO_W];
  logic [DIV_W-1:0] div_q  [QUO_W];
  logic [QUO_W-1:0] quo_q  [QUO_W];
  logic             ovf_q  [QUO_W];
  logic             dz_q   [QUO_W];

  // Result of the division step performed on each rank's contents.
  // Rank j resolves quotient bit QUO_W-1-j.
  logic [W-1:0]     n_part [QUO_W];
  logic [QUO_W-1:0] n_quo  [QUO_W];

  always_comb begin
    for (int j = 0; j < QUO_W; j++) begin
      n_part[j] = part_q[j];
      n_quo[j]  = quo_q[j];
    end
    for (int j = 0; j < QUO_W; j++) begin
      logic [W-1:0] sh;
      sh = W'(div_q[j]) << (QUO_W - 1 - j);
      if (part_q[j] >= sh) begin
        n_part[j]                = part_q[j] - sh;
        n_quo[j][QUO_W - 1 - j]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < QUO_W; j++) begin
        v_q[j]    <= 1'b0;
        part_q[j] <= '0;
        div_q[j]  <= '0;
        quo_q[j]  <= '0;
        ovf_q[j]  <= 1'b0;
        dz_q[j]   <= 1'b0;
      end
      out_valid <= 1'b0;
      out_quo   <= '0;
      out_rem   <= '0;
      out_ovf   <= 1'b0;
      out_dz    <= 1'b0;
    end else if (adv) begin
      // Rank 0 captures every cycle the pipe advances; v_q marks bubbles.
      // The divisor is captured with the address so later in_div changes
      // never reach items already in flight.
      v_q[0]    <= in_valid;
      part_q[0] <= adr_ext;
      div_q[0]  <= eff_div;
      quo_q[0]  <= '0;
      ovf_q[0]  <= in_ovf;
      dz_q[0]   <= in_dz;

      for (int j = 1; j < QUO_W; j++) begin
        v_q[j]    <= v_q[j-1];
        part_q[j] <= n_part[j-1];
        div_q[j]  <= div_q[j-1];
        quo_q[j]  <= n_quo[j-1];
        ovf_q[j]  <= ovf_q[j-1];
        dz_q[j]   <= dz_q[j-1];
      end

      out_valid <= v_q[LAST];
      if (v_q[LAST]) begin
        if (ovf_q[LAST] || dz_q[LAST]) begin
          // The step results are meaningless for these items; report a
          // saturated quotient and a zero offset instead.
          out_quo <= '1;
          out_rem <= '0;
        end else begin
          out_quo <= n_quo[LAST];
          out_rem <= n_part[LAST][DIV_W-1:0];
        end
        out_ovf <= ovf_q[LAST];
        out_dz  <= dz_q[LAST];
      end
    end
  end

endmodule

// File: tb/tb_adr_div_pipe.sv
// ----------------------------------------------------------------------------
// tb_adr_div_pipe
//
// Directed bench for adr_div_pipe with default parameters (ADR_W=9, QUO_W=6,
// DIV_W=4, DEF_DIV=12). Expected results are hand-computed constants pushed
// into an expected queue at acceptance time; a monitor pops them as results
// leave the block and also watches in_ready, result hold and latency.
// ----------------------------------------------------------------------------
module tb_adr_div_pipe;

  localparam int ADR_W = 9;
  localparam int QUO_W = 6;
  localparam int DIV_W = 4;
  localparam int EW    = 2 + QUO_W + DIV_W;

  // --------------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid;
  logic             in_ready;
  logic [ADR_W-1:0] in_adr;
  logic             div_sel;
  logic [DIV_W-1:0] in_div;
  logic             out_valid;
  logic             out_ready;
  logic [QUO_W-1:0] out_quo;
  logic [DIV_W-1:0] out_rem;
  logic             out_ovf;
  logic             out_dz;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  adr_div_pipe #(
    .ADR_W  (ADR_W),
    .QUO_W  (QUO_W),
    .DIV_W  (DIV_W),
    .DEF_DIV(12)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_adr   (in_adr),
    .div_sel  (div_sel),
    .in_div   (in_div),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_quo  (out_quo),
    .out_rem  (out_rem),
    .out_ovf  (out_ovf),
    .out_dz   (out_dz)
  );

  // --------------------------------------------------------------------------
  // Scoreboard state
  // --------------------------------------------------------------------------
  logic [EW-1:0] exp_q[$];   // {ovf, dz, quo, rem}
  int            acc_q[$];   // accepting edge number of each queued item
  int            n_tests = 0;
  int            n_fail  = 0;
  bit            lat_mode = 1'b0;
  int            n_out = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", tag, got, got, exp, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor: sampled on the falling edge, inputs change just after rising edge
  // --------------------------------------------------------------------------
  logic          held = 1'b0;
  logic [EW:0]   held_v;
  logic [EW-1:0] mon_e;
  int            mon_a;

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      check("in_ready", in_ready, !(out_valid && !out_ready));
      if (held) check("hold", {out_valid, out_ovf, out_dz, out_quo, out_rem}, held_v);
      if (out_valid && out_ready) begin
        n_out++;
        held = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          mon_a = acc_q.pop_front();
          check("quo", out_quo, mon_e[QUO_W+DIV_W-1:DIV_W]);
          check("rem", out_rem, mon_e[DIV_W-1:0]);
          check("ovf", out_ovf, mon_e[EW-1]);
          check("dz",  out_dz,  mon_e[EW-2]);
          if (lat_mode) check("latency", cyc - mon_a, QUO_W);
        end
      end else if (out_valid) begin
        held   = 1'b1;
        held_v = {out_valid, out_ovf, out_dz, out_quo, out_rem};
      end else begin
        held = 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Driver tasks
  // --------------------------------------------------------------------------
  task automatic send(input logic [ADR_W-1:0] adr, input logic sel, input logic [DIV_W-1:0] dv,
                      input int q, input int r, input bit ovf, input bit dz);
    bit done;
    int guard;
    in_valid = 1'b1;
    in_adr   = adr;
    div_sel  = sel;
    in_div   = dv;
    done     = 1'b0;
    guard    = 0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({ovf, dz, QUO_W'(q), DIV_W'(r)});
        acc_q.push_back(cyc + 1);
        done = 1'b1;
      end
      @(posedge clk); #1;
      guard++;
      if (!done && guard > 200) begin
        check("accept_timeout", 0, 1);
        done = 1'b1;
      end
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_adr   = '0;
    div_sel  = 1'b0;
    in_div   = '0;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    int g;
    idle();
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_quo",   out_quo,   0);
    check("rst_out_rem",   out_rem,   0);
    check("rst_out_ovf",   out_ovf,   0);
    check("rst_out_dz",    out_dz,    0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);

    // Default divisor, back to back, latency QUO_W
    lat_mode = 1'b1;
    send(9'd0,   1'b0, 4'd0, 0,  0,  1'b0, 1'b0);
    send(9'd300, 1'b0, 4'd0, 25, 0,  1'b0, 1'b0);
    send(9'd311, 1'b0, 4'd0, 25, 11, 1'b0, 1'b0);
    send(9'd511, 1'b0, 4'd0, 42, 7,  1'b0, 1'b0);
    idle();
    drain();

    // Runtime divisor, overflow boundary
    send(9'd319, 1'b1, 4'd5, 63, 4, 1'b0, 1'b0);
    send(9'd320, 1'b1, 4'd5, 63, 0, 1'b1, 1'b0);
    // Divisor change in flight
    send(9'd100, 1'b1, 4'd7, 14, 2, 1'b0, 1'b0);
    send(9'd100, 1'b1, 4'd3, 33, 1, 1'b0, 1'b0);
    // Divide by zero between normal neighbours
    send(9'd77,  1'b0, 4'd0, 6,  5, 1'b0, 1'b0);
    send(9'd50,  1'b1, 4'd0, 63, 0, 1'b0, 1'b1);
    send(9'd200, 1'b1, 4'd9, 22, 2, 1'b0, 1'b0);
    // Extreme divisors
    send(9'd511, 1'b1, 4'd15, 34, 1, 1'b0, 1'b0);
    send(9'd63,  1'b1, 4'd1,  63, 0, 1'b0, 1'b0);
    send(9'd64,  1'b1, 4'd1,  63, 0, 1'b1, 1'b0);
    idle();
    drain();
    lat_mode = 1'b0;

    // Backpressure: 10 items, out_ready low for 3 cycles mid-stream
    fork
      begin
        for (int i = 0; i < 10; i++) send(ADR_W'(13 * i), 1'b0, 4'd0, i, i, 1'b0, 1'b0);
        idle();
      end
      begin
        repeat (9) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-stream with 4 items in flight and a held result
    send(9'd1,  1'b0, 4'd0, 0, 1, 1'b0, 1'b0);
    send(9'd2,  1'b0, 4'd0, 0, 2, 1'b0, 1'b0);
    send(9'd3,  1'b0, 4'd0, 0, 3, 1'b0, 1'b0);
    send(9'd40, 1'b0, 4'd0, 3, 4, 1'b0, 1'b0);
    idle();
    out_ready = 1'b0;
    g = 0;
    while (!out_valid && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    check("pre_rst_out_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    exp_q.delete();
    acc_q.delete();
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_out = 0;
    send(9'd24, 1'b0, 4'd0, 2, 0, 1'b0, 1'b0);
    idle();
    drain();
    repeat (12) @(posedge clk);
    #1;
    check("post_rst_outputs", n_out, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
